menu_ctrl: RTL and testbench
============================

# menu_ctrl

Menu sequencer for the balance-board title screen. Debounces the five raw navigation buttons and owns the `cursor`, `mode` and `map` selections that drive the menu color renderer. Runs the menu → countdown → play → result flow and issues a one-cycle `start` pulse to the game core. Sits between the board button pins (already synchronized to `clk`) and both the VGA color path and the game logic.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles before a button level is accepted.
- `TICK_CYCLES`, default 100000000: cycles per countdown step.

**Ports**
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_ok` input 1 each: raw buttons, high = pressed, already synchronized to `clk`.
- `game_over` input 1: one-cycle pulse from the game core.
- `cursor` output 1: 0 = mode row, 1 = map row.
- `mode` output 1: `` `LIMITED `` or `` `CONTEST ``.
- `map` output 2: 0..2; the value 3 is never driven.
- `count` output 2: countdown digit 3..1; 0 outside COUNTDOWN.
- `start` output 1: one-cycle pulse on COUNTDOWN→PLAY.
- `in_game` output 1: high in PLAY.

## Operation

- **Per-button debounce**
  - A counter increments while raw ≠ accepted level and clears when they are equal.
  - On reaching `DEBOUNCE_CYCLES` the accepted level flips.
  - A 0→1 flip produces a one-cycle press event. Releases produce no event.
- **Event priority:** when several events occur in the same cycle, only the highest-priority one is acted on: ok > up > down > left > right. The rest are dropped.
- **FSM states:** MENU, COUNTDOWN, PLAY, RESULT.
- **MENU**
  - up → `cursor`=0.
  - down → `cursor`=1.
  - left/right with `cursor`=0 → toggle `mode`.
  - right with `cursor`=1 → `map`+1.
  - left with `cursor`=1 → `map`−1.
  - ok → COUNTDOWN, with `count`=3 and the tick counter cleared.
- **COUNTDOWN**
  - Each `TICK_CYCLES` expiry decrements `count`.
  - On the expiry with `count`=1: `count`→0, `start`=1 for that one cycle, next state PLAY.
  - Buttons are ignored; the selections are frozen.
- **PLAY:** `in_game`=1; `game_over` → RESULT. Buttons are ignored.
- **RESULT:** ok → MENU. Selections are retained from before the game.
- `game_over` outside PLAY is ignored.
- **Reset values:** `cursor`=0, `mode`=`` `LIMITED ``, `map`=0, `count`=0, `start`=0, `in_game`=0, state MENU, all debounce levels 0, all counters 0.
- Reset asserted in any state overrides everything and returns to the reset values on the next edge.

## Timing

- All outputs are registered.
- **Debounce latency:** raw held high from sampled edge N gives a press event high during cycle N+`DEBOUNCE_CYCLES`. A selection output changes on the edge that ends the event cycle.
- A raw glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- **Countdown duration:** 3·`TICK_CYCLES` cycles from entering COUNTDOWN to `start`. `in_game` rises on the edge after the `start` cycle.
- **Counter widths:** each counter is `$clog2` of its parameter plus 1.

## Configuration

- `MENU_WRAP_EN` defined:
  - `map` right at 2 → 0.
  - `map` left at 0 → 2.
- `MENU_WRAP_EN` undefined:
  - `map` saturates: right at 2 stays 2, left at 0 stays 0.
- `mode` toggling is unaffected by the macro.

## Structure

- **Shared package (`head.v`):** `` `LIMITED ``, `` `CONTEST ``, FSM state encodings (`` `ST_MENU ``, `` `ST_COUNTDOWN ``, `` `ST_PLAY ``, `` `ST_RESULT ``), `` `MAP_MAX `` = 2.
- **Sub-module:** `btn_debounce`, parameterized by `DEBOUNCE_CYCLES`, with ports `clk`, `rst`, `raw` → `level`, `press`. It is instantiated five times.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES`=4, `TICK_CYCLES`=10.

1. **Reset:** `rst` high for 2 cycles → `cursor`=0, `mode`=`` `LIMITED ``, `map`=0, `count`=0, `start`=0, `in_game`=0.
2. **Debounce:**
   - `btn_down` high 3 cycles then low → no change.
   - `btn_down` high 6 cycles → `cursor`=1 exactly 5 edges after the first high sample.
3. **Map stepping:** with `cursor`=1, three right presses → `map` 1, 2, then 0 (`MENU_WRAP_EN`) or 2 (no macro). One left press from 0 → 2 or 0 respectively.
4. **Simultaneous events:** `btn_ok` and `btn_up` rise together with `cursor`=1 → COUNTDOWN entered, `cursor` stays 1.
5. **Countdown:** after ok, `count` = 3 for 10 cycles, 2 for 10, 1 for 10 → `start` high exactly one cycle, then `in_game`=1. Buttons pressed during the countdown change nothing.
6. **Result and reset:**
   - `game_over` pulse in PLAY → RESULT, `in_game`=0; ok → MENU with `mode`/`map` unchanged.
   - `rst` asserted mid-COUNTDOWN → MENU, `count`=0, no `start` pulse.

Source files
------------

// File: rtl/menu_ctrl_pkg.sv
// menu_ctrl_pkg
//   Shared definitions for the balance-board menu sequencer: mode encodings,
//   FSM state encoding, map range, button indices and the event priority
//   helper used to reduce simultaneous presses to a single action.
package menu_ctrl_pkg;

  localparam logic LIMITED = 1'b0;
  localparam logic CONTEST = 1'b1;

  localparam logic [1:0] MAP_MAX = 2'd2;

  typedef enum logic [1:0] {
    ST_MENU      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_RESULT    = 2'd3
  } state_t;

  // Bit positions of the buttons in the packed press/level vectors.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_OK    = 4;
  localparam int NUM_BTN   = 5;

  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_OK    = 3'd1,
    EV_UP    = 3'd2,
    EV_DOWN  = 3'd3,
    EV_LEFT  = 3'd4,
    EV_RIGHT = 3'd5
  } event_t;

  // Only the highest-priority press of a cycle is acted on: ok > up > down > left > right.
  function automatic event_t pick_event(input logic [NUM_BTN-1:0] press);
    if (press[BTN_OK])         return EV_OK;
    else if (press[BTN_UP])    return EV_UP;
    else if (press[BTN_DOWN])  return EV_DOWN;
    else if (press[BTN_LEFT])  return EV_LEFT;
    else if (press[BTN_RIGHT]) return EV_RIGHT;
    else                       return EV_NONE;
  endfunction

endpackage

// File: rtl/menu_ctrl_if.sv
// menu_ctrl_if
//   Bundle of the menu sequencer's board-side inputs and its outputs.
//   master : board / game side (drives buttons and game_over, reads selections)
//   slave  : menu_ctrl
//   Signals:
//     btn_up/down/left/right/ok : raw buttons, high = pressed, synchronous to clk
//     game_over                 : one-cycle pulse from the game core
//     cursor                    : 0 = mode row, 1 = map row
//     mode                      : LIMITED / CONTEST
//     map                       : 0..2
//     count                     : countdown digit 3..1, 0 outside countdown
//     start                     : one-cycle pulse when play begins
//     in_game                   : high while playing
interface menu_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_ok;
  logic       game_over;
  logic       cursor;
  logic       mode;
  logic [1:0] map;
  logic [1:0] count;
  logic       start;
  logic       in_game;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_ok, game_over,
    input  cursor, mode, map, count, start, in_game
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_ok, game_over,
    output cursor, mode, map, count, start, in_game
  );
endinterface

// File: rtl/menu_ctrl_btn_debounce.sv
// btn_debounce
//   Single-button debouncer. A counter runs while the raw input differs from
//   the accepted level and clears whenever they agree; once it has reached
//   DEBOUNCE_CYCLES the accepted level flips on the following edge. A 0->1
//   flip raises press for exactly one cycle; releases raise nothing.
//   Ports:
//     clk   : system clock
//     rst   : synchronous, active-high reset
//     raw   : button input, already synchronized to clk
//     level : accepted (debounced) level
//     press : one-cycle pulse on an accepted 0->1 flip
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CNT_FULL) begin
        cnt   <= '0;
        level <= raw;
        press <= raw;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/menu_ctrl.sv
// menu_ctrl
//   Title-screen menu sequencer: debounces the five navigation buttons, owns
//   the cursor/mode/map selections and runs menu -> countdown -> play ->
//   result, pulsing start for one cycle when play begins.
//   Ports:
//     clk : system clock
//     rst : synchronous, active-high reset
//     bus : menu_ctrl_if.slave (buttons, game_over in; selections, count,
//           start, in_game out; all outputs registered)
//   Build option:
//     MENU_WRAP_EN : when defined, map steps wrap 2->0 and 0->2; otherwise
//                    map saturates at 0 and 2.
//
//   state        | meaning
//   -------------+-----------------------------------------------
//   ST_MENU      | selections editable, ok starts the countdown
//   ST_COUNTDOWN | count 3..1, one step per TICK_CYCLES
//   ST_PLAY      | game running, waits for game_over
//   ST_RESULT    | score screen, ok returns to the menu
module menu_ctrl
  import menu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic rst,
  menu_ctrl_if.slave bus
);

  localparam int TW = $clog2(TICK_CYCLES) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  event_t             ev;

  state_t        state_q, state_nx;
  logic          cursor_q, cursor_d;
  logic          mode_q, mode_d;
  logic [1:0]    map_q, map_d;
  logic [1:0]    count_q, count_d;
  logic          start_q, start_d;
  logic          in_game_q, in_game_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          tick_done;

  assign raw = {bus.btn_ok, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  // Only press events drive the menu; the accepted levels have no consumer here.
  logic unused_level;
  assign unused_level = ^level;

  assign ev        = pick_event(press);
  assign tick_done = (tick_q == TICK_LAST);

  function automatic logic [1:0] map_right(input logic [1:0] m);
`ifdef MENU_WRAP_EN
    return (m >= MAP_MAX) ? 2'd0 : m + 2'd1;
`else
    return (m >= MAP_MAX) ? MAP_MAX : m + 2'd1;
`endif
  endfunction

  function automatic logic [1:0] map_left(input logic [1:0] m);
`ifdef MENU_WRAP_EN
    return (m == 2'd0) ? MAP_MAX : m - 2'd1;
`else
    return (m == 2'd0) ? 2'd0 : m - 2'd1;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_MENU;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_MENU:      if (ev == EV_OK) state_nx = ST_COUNTDOWN;
      ST_COUNTDOWN: if (tick_done && count_q == 2'd1) state_nx = ST_PLAY;
      ST_PLAY:      if (bus.game_over) state_nx = ST_RESULT;
      ST_RESULT:    if (ev == EV_OK) state_nx = ST_MENU;
      default:      state_nx = ST_MENU;
    endcase
  end

  always_comb begin
    cursor_d  = cursor_q;
    mode_d    = mode_q;
    map_d     = map_q;
    count_d   = count_q;
    start_d   = 1'b0;
    tick_d    = '0;
    // in_game follows the state one edge later so it rises after the start cycle.
    in_game_d = (state_q == ST_PLAY);
    case (state_q)
      ST_MENU: begin
        case (ev)
          EV_OK:    count_d  = 2'd3;
          EV_UP:    cursor_d = 1'b0;
          EV_DOWN:  cursor_d = 1'b1;
          EV_LEFT:  if (cursor_q) map_d = map_left(map_q);  else mode_d = ~mode_q;
          EV_RIGHT: if (cursor_q) map_d = map_right(map_q); else mode_d = ~mode_q;
          default: ;
        endcase
      end
      ST_COUNTDOWN: begin
        if (tick_done) begin
          count_d = count_q - 2'd1;
          if (count_q == 2'd1) start_d = 1'b1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cursor_q  <= 1'b0;
      mode_q    <= LIMITED;
      map_q     <= 2'd0;
      count_q   <= 2'd0;
      start_q   <= 1'b0;
      in_game_q <= 1'b0;
      tick_q    <= '0;
    end else begin
      cursor_q  <= cursor_d;
      mode_q    <= mode_d;
      map_q     <= map_d;
      count_q   <= count_d;
      start_q   <= start_d;
      in_game_q <= in_game_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.cursor  = cursor_q;
  assign bus.mode    = mode_q;
  assign bus.map     = map_q;
  assign bus.count   = count_q;
  assign bus.start   = start_q;
  assign bus.in_game = in_game_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// tb_menu_ctrl
//   Self-checking bench for menu_ctrl with DEBOUNCE_CYCLES=4, TICK_CYCLES=10.
//   A behavioural model tracks cursor/mode/map per accepted press; timing of
//   debounce and countdown is checked against cycle arithmetic.
//   Honors MENU_WRAP_EN in the same way as the design.
module tb_menu_ctrl;
  import menu_ctrl_pkg::*;

  localparam int DEB  = 4;
  localparam int TICK = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  menu_ctrl_if bus();

  menu_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES    (TICK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int m_cursor, m_mode, m_map;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_up    = v;
      1: bus.btn_down  = v;
      2: bus.btn_left  = v;
      3: bus.btn_right = v;
      default: bus.btn_ok = v;
    endcase
  endtask

  task automatic tap(input int b, input int hold, input int rel);
    set_btn(b, 1'b1);
    step(hold);
    set_btn(b, 1'b0);
    step(rel);
  endtask

  function automatic int model_right(input int m);
`ifdef MENU_WRAP_EN
    return (m + 1) % 3;
`else
    return (m < 2) ? m + 1 : 2;
`endif
  endfunction

  function automatic int model_left(input int m);
`ifdef MENU_WRAP_EN
    return (m + 2) % 3;
`else
    return (m > 0) ? m - 1 : 0;
`endif
  endfunction

  // Menu rules applied to one accepted press of button b (0 up, 1 down, 2 left, 3 right).
  task automatic model_press(input int b);
    case (b)
      0: m_cursor = 0;
      1: m_cursor = 1;
      2: if (m_cursor == 0) m_mode = 1 - m_mode; else m_map = model_left(m_map);
      3: if (m_cursor == 0) m_mode = 1 - m_mode; else m_map = model_right(m_map);
      default: ;
    endcase
  endtask

  task automatic check_sel(input string tag);
    check_val({tag, ".cursor"}, 32'(bus.cursor), m_cursor);
    check_val({tag, ".mode"},   32'(bus.mode),   m_mode);
    check_val({tag, ".map"},    32'(bus.map),    m_map);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int b = 0; b < 5; b++) set_btn(b, 1'b0);
    bus.game_over = 1'b0;
    step(cycles);
    rst = 1'b0;
    m_cursor = 0;
    m_mode   = 0;
    m_map    = 0;
  endtask

  // Press ok (optionally with up) and wait, bounded, for the countdown to start.
  task automatic enter_countdown(input string tag, input logic with_up);
    int waited;
    set_btn(4, 1'b1);
    if (with_up) set_btn(0, 1'b1);
    waited = 0;
    do begin
      step();
      waited++;
    end while (bus.count == 2'd0 && waited < 20);
    set_btn(4, 1'b0);
    set_btn(0, 1'b0);
    check_val({tag, ".entry_latency"}, waited, DEB + 2);
    check_val({tag, ".count_first"}, 32'(bus.count), 3);
  endtask

  initial begin
    do_reset(2);
    check_sel("reset");
    check_val("reset.count",   32'(bus.count),   0);
    check_val("reset.start",   32'(bus.start),   0);
    check_val("reset.in_game", 32'(bus.in_game), 0);

    // Short glitch must not be accepted.
    tap(1, DEB - 1, 8);
    check_sel("glitch");

    // Held press: cursor changes on the 5th edge after the first high sample.
    set_btn(1, 1'b1);
    for (int i = 1; i <= DEB + 2; i++) begin
      step();
      check_val($sformatf("deb_latency_%0d", i), 32'(bus.cursor), (i >= DEB + 2) ? 1 : 0);
    end
    set_btn(1, 1'b0);
    step(DEB + 2);
    model_press(1);
    check_sel("after_down");

    // Map stepping on the map row.
    for (int k = 0; k < 3; k++) begin
      tap(3, 6, 6);
      model_press(3);
      check_val($sformatf("map_right_%0d", k), 32'(bus.map), m_map);
    end
    tap(2, 6, 6);
    model_press(2);
    check_val("map_left", 32'(bus.map), m_map);

    // Randomized navigation with occasional sub-threshold glitches.
    for (int k = 0; k < 30; k++) begin
      int act;
      act = $urandom_range(0, 4);
      if (act == 4) begin
        tap($urandom_range(0, 3), $urandom_range(1, DEB - 1), DEB + 2);
      end else begin
        tap(act, $urandom_range(DEB + 1, DEB + 4), $urandom_range(DEB + 1, DEB + 4));
        model_press(act);
      end
      check_sel($sformatf("rand_%0d", k));
    end

    // Simultaneous ok+up with cursor on the map row: ok wins, cursor stays 1.
    tap(1, 6, 6);
    model_press(1);
    enter_countdown("simul", 1'b1);
    check_val("simul.cursor", 32'(bus.cursor), 1);

    // Countdown timing, with button activity that must be ignored.
    for (int i = 1; i < 3 * TICK; i++) begin
      if (i == 2)  set_btn(3, 1'b1);
      if (i == 10) set_btn(3, 1'b0);
      if (i == 14) set_btn(0, 1'b1);
      if (i == 21) set_btn(0, 1'b0);
      step();
      check_val($sformatf("cd_count_%0d", i), 32'(bus.count), 3 - i / TICK);
      check_val($sformatf("cd_start_%0d", i), 32'(bus.start), 0);
    end
    step();
    check_val("cd_end.count",   32'(bus.count),   0);
    check_val("cd_end.start",   32'(bus.start),   1);
    check_val("cd_end.in_game", 32'(bus.in_game), 0);
    step();
    check_val("play.start",   32'(bus.start),   0);
    check_val("play.in_game", 32'(bus.in_game), 1);
    check_sel("cd_frozen");

    // Play, then game over into result, then ok back to the menu.
    step(5);
    check_val("play_hold.in_game", 32'(bus.in_game), 1);
    bus.game_over = 1'b1;
    step();
    bus.game_over = 1'b0;
    step();
    check_val("result.in_game", 32'(bus.in_game), 0);
    tap(4, 6, 6);
    check_sel("result_to_menu");
    tap(0, 6, 6);
    model_press(0);
    check_sel("menu_alive");
    bus.game_over = 1'b1;
    step();
    bus.game_over = 1'b0;
    step(3);
    check_val("go_in_menu.in_game", 32'(bus.in_game), 0);
    check_val("go_in_menu.count",   32'(bus.count),   0);

    // Reset in the middle of the countdown.
    tap(3, 6, 6);
    model_press(3);
    enter_countdown("rst_cd", 1'b0);
    step(12);
    check_val("rst_cd.count_mid", 32'(bus.count), 2);
    do_reset(1);
    check_sel("rst_cd");
    check_val("rst_cd.count", 32'(bus.count), 0);
    for (int i = 0; i < 4 * TICK; i++) begin
      step();
      check_val($sformatf("rst_cd.no_start_%0d", i), 32'(bus.start | bus.in_game), 0);
    end
    check_val("rst_cd.count_after", 32'(bus.count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
